// File: rtl/btn_debounce_capture.sv
// btn_debounce_capture: push-button debouncer with switch-operand capture.
// Raw button and switches are double-flop synchronized, then the button is
// qualified by STABLE_SAMPLES consecutive equal samples taken on sample_tick.
// An accepted press yields a one-cycle press_pulse, captures the switches into
// data_out and bumps press_count; an accepted release yields release_pulse.
// Optional build macro: AUTO_REPEAT_EN (re-fires press while the button is held).
module btn_debounce_capture #(
    parameter int STABLE_SAMPLES = 4,
    parameter int DATA_W         = 4,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] sw_raw,
    output logic              btn_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        press_count
);

    // Catch illegal configurations at elaboration time.
    if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 255 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_capture: illegal parameter value");
    end

    localparam logic [7:0] SS_LIMIT = 8'(STABLE_SAMPLES);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    logic              btn_meta_q, btn_s_q;
    logic [DATA_W-1:0] sw_meta_q, sw_s_q;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        count_q, count_d;
    logic              take_press;

`ifdef AUTO_REPEAT_EN
    logic [15:0]       rc_q, rc_d, rc_inc;
    logic              rep_q, rep_d;
`endif

    // Two-flop synchronizers for the asynchronous button and switch inputs.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw_raw;
            sw_s_q     <= sw_meta_q;
        end
    end

    // Debounce FSM next state, stable counter and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 8'd1;
        press_d    = 1'b0;
        release_d  = 1'b0;
        data_d     = data_q;
        count_d    = count_q;
        take_press = 1'b0;
`ifdef AUTO_REPEAT_EN
        rc_d       = rc_q;
        rep_d      = rep_q;
        rc_inc     = rc_q + 16'd1;
`endif
        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_s_q) begin
                        state_d = ST_ARMING;
                        cnt_d   = 8'd1;
                    end
                end
                ST_ARMING: begin
                    if (!btn_s_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_inc == SS_LIMIT) begin
                        state_d    = ST_HELD;
                        cnt_d      = 8'd0;
                        take_press = 1'b1;
`ifdef AUTO_REPEAT_EN
                        rc_d       = 16'd0;
                        rep_d      = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!btn_s_q) begin
                        state_d = ST_RELEASING;
                        cnt_d   = 8'd1;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        // First repeat after REPEAT_DELAY ticks, then every REPEAT_PERIOD.
                        if (rc_inc == (rep_q ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY))) begin
                            take_press = 1'b1;
                            rc_d       = 16'd0;
                            rep_d      = 1'b1;
                        end else begin
                            rc_d = rc_inc;
                        end
`endif
                    end
                end
                ST_RELEASING: begin
                    if (btn_s_q) begin
                        state_d = ST_HELD;
                        cnt_d   = 8'd0;
`ifdef AUTO_REPEAT_EN
                        rc_d    = 16'd0;
                        rep_d   = 1'b0;
`endif
                    end else if (cnt_inc == SS_LIMIT) begin
                        state_d   = ST_IDLE;
                        cnt_d     = 8'd0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
        if (take_press) begin
            press_d = 1'b1;
            data_d  = sw_s_q;
            count_d = count_q + 8'd1;
        end
        level_d = (state_d == ST_HELD) || (state_d == ST_RELEASING);
    end

    // FSM state and output registers.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            data_q    <= '0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Auto-repeat tick counter, active only while held.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            rc_q  <= 16'd0;
            rep_q <= 1'b0;
        end else begin
            rc_q  <= rc_d;
            rep_q <= rep_d;
        end
    end
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign data_out      = data_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce_capture.sv
// Testbench for btn_debounce_capture: randomized and directed button patterns
// checked against a run-length reference model of the debounce rules.
module tb_btn_debounce_capture;

    localparam int SS  = 4;
    localparam int RD  = 5;
    localparam int RP  = 3;
    localparam int GAP = 4;

    logic       clk_100M;
    logic       rst;
    logic       sample_tick;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [3:0] data_out;
    logic [7:0] press_count;

    btn_debounce_capture #(
        .STABLE_SAMPLES(SS),
        .DATA_W        (4),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk_100M     (clk_100M),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .btn_raw      (btn_raw),
        .sw_raw       (sw_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .data_out     (data_out),
        .press_count  (press_count)
    );

    // Clock and reset
    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the level flips after SS consecutive opposite samples.
    logic [3:0] exp_q[$];
    logic       m_level;
    int         m_run;
    int         m_held;
    logic [7:0] m_count;
    logic [3:0] m_data;
    logic       exp_press;
    logic       exp_release;

    // Observations from the last tick
    logic       o_press, o_release, o_level;
    logic [3:0] o_data;
    logic [7:0] o_count;
    int         o_stray;

    task automatic model_reset();
        m_level = 1'b0; m_run = 0; m_held = 0; m_count = 8'd0; m_data = 4'd0;
        exp_press = 1'b0; exp_release = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_tick(input logic b, input logic [3:0] sw);
        exp_press = 1'b0;
        exp_release = 1'b0;
        if (!m_level) begin
            if (b) begin
                m_run++;
                if (m_run == SS) begin
                    m_level = 1'b1; m_run = 0; m_held = 0; exp_press = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!b) begin
                m_run++;
                if (m_run == SS) begin
                    m_level = 1'b0; m_run = 0; exp_release = 1'b1;
                end
            end else if (m_run != 0) begin
                m_run = 0; m_held = 0;
            end else begin
                m_held++;
`ifdef AUTO_REPEAT_EN
                if (m_held >= RD && ((m_held - RD) % RP) == 0) exp_press = 1'b1;
`endif
            end
        end
        if (exp_press) begin
            m_count = m_count + 8'd1;
            m_data  = sw;
            exp_q.push_back(sw);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; sample_tick = 1'b0; btn_raw = 1'b0; sw_raw = 4'd0;
        repeat (3) @(posedge clk_100M);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Driver: hold inputs long enough to pass the synchronizer, issue one tick,
    // capture outputs on the cycle after the tick edge.
    task automatic drive_tick(input logic b, input logic [3:0] sw);
        btn_raw = b;
        sw_raw  = sw;
        o_stray = 0;
        repeat (GAP) begin
            @(posedge clk_100M); #1;
            if (press_pulse || release_pulse) o_stray++;
        end
        sample_tick = 1'b1;
        @(posedge clk_100M); #1;
        sample_tick = 1'b0;
        o_press = press_pulse; o_release = release_pulse; o_level = btn_level;
        o_data = data_out; o_count = press_count;
        model_tick(b, sw);
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; sample_tick = 1'b0; btn_raw = 1'b0; sw_raw = 4'hF;
        #2;
        n_cmp++; if ({btn_level, press_pulse, release_pulse, data_out, press_count} !== 15'd0) begin
            n_err++; $display("FAIL reset_outputs: got %0h want 0", {btn_level, press_pulse, release_pulse, data_out, press_count});
        end
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            drive_tick(1'b0, 4'($urandom_range(0, 15)));
            pulses += o_stray + int'(o_press) + int'(o_release) + int'(o_level);
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL idle_activity: got %0d want 0", pulses); end
        n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL idle_count: got %0d want 0", press_count); end
        n_cmp++; if (data_out !== 4'd0) begin n_err++; $display("FAIL idle_data: got %0h want 0", data_out); end
    endtask

    task automatic test_clean_press();
        int npress;
        apply_reset();
        npress = 0;
        for (int i = 0; i < 6; i++) begin
            drive_tick(1'b1, 4'hB);
            npress += int'(o_press);
            n_cmp++; if (o_press !== exp_press) begin n_err++; $display("FAIL clean_press_pulse tick %0d: got %0b want %0b", i, o_press, exp_press); end
            n_cmp++; if (o_level !== m_level) begin n_err++; $display("FAIL clean_press_level tick %0d: got %0b want %0b", i, o_level, m_level); end
        end
        n_cmp++; if (npress != 1) begin n_err++; $display("FAIL clean_press_num: got %0d want 1", npress); end
        n_cmp++; if (o_data !== 4'hB) begin n_err++; $display("FAIL clean_press_data: got %0h want b", o_data); end
        n_cmp++; if (o_count !== 8'd1) begin n_err++; $display("FAIL clean_press_count: got %0d want 1", o_count); end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b000101;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_tick(pat[i], 4'($urandom_range(0, 15)));
            n_cmp++; if (o_press !== 1'b0 || o_level !== 1'b0) begin
                n_err++; $display("FAIL bounce tick %0d: got press=%0b level=%0b want 0 0", i, o_press, o_level);
            end
        end
        n_cmp++; if (o_count !== 8'd0) begin n_err++; $display("FAIL bounce_count: got %0d want 0", o_count); end
    endtask

    task automatic test_release_bounce();
        logic [6:0] pat;
        int nrel;
        pat = 7'b0000100;
        apply_reset();
        for (int i = 0; i < SS; i++) drive_tick(1'b1, 4'h5);
        nrel = 0;
        for (int i = 0; i < 7; i++) begin
            drive_tick(pat[i], 4'($urandom_range(0, 15)));
            nrel += int'(o_release);
            n_cmp++; if (o_level !== m_level) begin n_err++; $display("FAIL rel_bounce_level tick %0d: got %0b want %0b", i, o_level, m_level); end
            n_cmp++; if (o_release !== exp_release) begin n_err++; $display("FAIL rel_bounce_pulse tick %0d: got %0b want %0b", i, o_release, exp_release); end
        end
        n_cmp++; if (nrel != 1) begin n_err++; $display("FAIL rel_bounce_num: got %0d want 1", nrel); end
        n_cmp++; if (o_data !== 4'h5) begin n_err++; $display("FAIL rel_bounce_data: got %0h want 5", o_data); end
    endtask

    task automatic test_wrap();
        int npress;
        apply_reset();
        npress = 0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < SS; i++) begin
                drive_tick(1'b1, 4'($urandom_range(0, 15)));
                npress += int'(o_press);
            end
            for (int i = 0; i < SS; i++) drive_tick(1'b0, 4'($urandom_range(0, 15)));
        end
        n_cmp++; if (npress != 256) begin n_err++; $display("FAIL wrap_presses: got %0d want 256", npress); end
        n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", press_count); end
        n_cmp++; if (data_out !== m_data) begin n_err++; $display("FAIL wrap_data: got %0h want %0h", data_out, m_data); end
    endtask

    task automatic test_async_reset();
        int act;
        apply_reset();
        for (int i = 0; i < SS; i++) drive_tick(1'b1, 4'h7);
        for (int i = 0; i < SS; i++) drive_tick(1'b0, 4'h7);
        drive_tick(1'b1, 4'h3);
        drive_tick(1'b1, 4'h3);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({btn_level, press_pulse, release_pulse, data_out, press_count} !== 15'd0) begin
            n_err++; $display("FAIL async_reset_outputs: got %0h want 0", {btn_level, press_pulse, release_pulse, data_out, press_count});
        end
        btn_raw = 1'b0;
        @(posedge clk_100M); #1 rst = 1'b0;
        model_reset();
        act = 0;
        for (int i = 0; i < SS + 2; i++) begin
            drive_tick(1'b0, 4'h3);
            act += o_stray + int'(o_press) + int'(o_release) + int'(o_level);
        end
        n_cmp++; if (act != 0 || press_count !== 8'd0) begin
            n_err++; $display("FAIL async_reset_after: got activity=%0d count=%0d want 0 0", act, press_count);
        end
    endtask

    task automatic test_random();
        logic       val;
        int         run;
        logic [3:0] want;
        apply_reset();
        val = 1'b0; run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                val = ~val;
                run = $urandom_range(1, 7);
            end
            run--;
            drive_tick(val, 4'($urandom_range(0, 15)));
            n_cmp++; if (o_press !== exp_press) begin n_err++; $display("FAIL rand_press tick %0d: got %0b want %0b", i, o_press, exp_press); end
            n_cmp++; if (o_release !== exp_release) begin n_err++; $display("FAIL rand_release tick %0d: got %0b want %0b", i, o_release, exp_release); end
            n_cmp++; if (o_level !== m_level) begin n_err++; $display("FAIL rand_level tick %0d: got %0b want %0b", i, o_level, m_level); end
            n_cmp++; if (o_count !== m_count) begin n_err++; $display("FAIL rand_count tick %0d: got %0d want %0d", i, o_count, m_count); end
            n_cmp++; if (o_stray != 0) begin n_err++; $display("FAIL rand_stray_pulse tick %0d: got %0d want 0", i, o_stray); end
            if (o_press) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rand_data tick %0d: got %0h want no press", i, o_data);
                end else begin
                    want = exp_q.pop_front();
                    if (o_data !== want) begin n_err++; $display("FAIL rand_data tick %0d: got %0h want %0h", i, o_data, want); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missed_presses: got %0d want 0", exp_q.size()); end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int npress;
        apply_reset();
        npress = 0;
        for (int i = 0; i < SS + 14; i++) begin
            drive_tick(1'b1, 4'($urandom_range(0, 15)));
            npress += int'(o_press);
            n_cmp++; if (o_press !== exp_press) begin n_err++; $display("FAIL repeat_pulse tick %0d: got %0b want %0b", i, o_press, exp_press); end
            n_cmp++; if (o_data !== m_data) begin n_err++; $display("FAIL repeat_data tick %0d: got %0h want %0h", i, o_data, m_data); end
        end
        n_cmp++; if (npress != 5 || o_count !== 8'd5) begin
            n_err++; $display("FAIL repeat_total: got pulses=%0d count=%0d want 5 5", npress, o_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
